// File: rtl/load_writeback.sv
// rtl/load_writeback.sv - load unit: fetch a memory word, extract/extend the addressed lane, write it back
//
// Purpose: accepts one load request at a time, issues a word-aligned memory
// read, waits for the ack, then writes the sign/zero-extended byte, half or
// word into the register file. WB can accept the next request, so
// back-to-back loads run without an extra idle cycle.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                request handshake
//   in_rd, in_addr, in_funct3        destination register, byte address, load type
//   mem_req, mem_addr                word-aligned read request (held until ack)
//   mem_ack, mem_rdata               read response (only honoured in REQ)
//   rf_wen, rf_waddr, rf_wdata       register-file write port
//   busy                             high while not in IDLE
//   misalign                         one-cycle misaligned-access flag
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned LH/LHU/LW
// accesses with a misalign pulse instead of a memory access.
module load_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy,
  output logic                  misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  accept;
  logic                  misaligned_req;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] ext_data;

  assign accept = in_valid && in_ready;

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q;

  // Bytes are always aligned; halves need addr[0]=0; LW (and aliases 3/6/7) need addr[1:0]=0.
  always_comb begin
    misaligned_req = 1'b0;
    case (in_funct3)
      3'd0, 3'd4: misaligned_req = 1'b0;
      3'd1, 3'd5: misaligned_req = in_addr[0];
      default:    misaligned_req = |in_addr[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && misaligned_req;
    end
  end

  assign misalign = misalign_q;
`else
  assign misaligned_req = 1'b0;
  assign misalign       = 1'b0;
`endif

  // Lane extraction from the returning word, steered by the latched address.
  assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = mem_rdata;
    case (funct3_q)
      3'd0:    ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'd1:    ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'd4:    ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'd5:    ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    data_d   = data_q;
    case (state_q)
      IDLE, WB: begin
        if (accept) begin
          rd_d     = in_rd;
          addr_d   = in_addr;
          funct3_d = in_funct3;
          // A rejected (misaligned) request never reaches memory.
          state_d  = misaligned_req ? IDLE : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          data_d  = ext_data;
          state_d = WB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      data_q   <= data_d;
    end
  end

  assign in_ready = (state_q != REQ);
  assign busy     = (state_q != IDLE);
  assign mem_req  = (state_q == REQ);
  assign mem_addr = (state_q == REQ) ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  // x0 is hard-wired zero: the access still happens but nothing is written.
  assign rf_wen   = (state_q == WB) && (rd_q != '0);
  assign rf_waddr = rd_q;
  assign rf_wdata = data_q;

endmodule

// File: tb/tb_load_writeback.sv
// tb/tb_load_writeback.sv - scoreboard bench for load_writeback with a reference load model
module tb_load_writeback;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_addr;
  logic [2:0]    in_funct3;
  logic          mem_req;
  logic [DW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          misalign;

  load_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_addr(in_addr), .in_funct3(in_funct3),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] wdata;
    int            cycle;
  } wb_t;

  typedef struct {
    logic [DW-1:0] addr;
    logic [DW-1:0] rdata;
    int            delay;
  } mem_t;

  wb_t  wb_q[$];
  mem_t mem_q[$];
  int   mis_q[$];

  int checks   = 0;
  int failures = 0;
  bit hold_resp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load semantics: shift the addressed lane down, then extend.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] addr,
                                        input logic [31:0] rdata);
    int unsigned b;
    int unsigned h;
    b = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return addr[0];
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; returns at a later negedge with in_valid dropped.
  task automatic do_load(input logic [AW-1:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int delay);
    int   n;
    mem_t m;
    wb_t  w;
    n = 0;
    in_valid  = 1'b1;
    in_rd     = rd;
    in_addr   = addr;
    in_funct3 = f3;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else if (is_mis(f3, addr)) begin
      mis_q.push_back(cyc + 1);
    end else begin
      m.addr  = addr;
      m.rdata = rdata;
      m.delay = delay;
      mem_q.push_back(m);
      if (rd != '0) begin
        w.rd    = rd;
        w.wdata = model(f3, addr, rdata);
        w.cycle = cyc + 2 + delay;
        wb_q.push_back(w);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_rd     = AW'($urandom);
    in_addr   = $urandom;
    in_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0 || mis_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'b0, n < 200}, 32'd1);
  endtask

  // Memory responder: checks the request side, answers after the chosen delay.
  initial begin : responder
    mem_t cur;
    int   cnt;
    bit   active;
    active    = 1'b0;
    cnt       = 0;
    cur.addr  = '0;
    cur.rdata = '0;
    cur.delay = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (hold_resp || !rst_n) begin
        active = 1'b0;
      end else begin
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        if (!mem_req) begin
          active = 1'b0;
        end else begin
          if (!active) begin
            if (mem_q.size() == 0) begin
              check("unexpected_mem_req", {31'b0, mem_req}, 32'd0);
              cur.addr  = mem_addr;
              cur.rdata = '0;
              cur.delay = 0;
            end else begin
              cur = mem_q.pop_front();
            end
            active = 1'b1;
            cnt    = cur.delay;
            check("mem_addr", mem_addr, {cur.addr[31:2], 2'b00});
          end else begin
            cnt--;
            check("mem_addr_stable", mem_addr, {cur.addr[31:2], 2'b00});
          end
          check("in_ready_in_req", {31'b0, in_ready}, 32'd0);
          check("busy_in_req", {31'b0, busy}, 32'd1);
          mem_ack   = (cnt <= 0);
          mem_rdata = (cnt <= 0) ? cur.rdata : $urandom;
        end
      end
    end
  end

  // Monitor: every write-back and misalign pulse must match the head of its queue.
  initial begin : monitor
    wb_t e;
    int  mc;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rf_wen) begin
          if (wb_q.size() == 0) begin
            check("unexpected_rf_wen", {31'b0, rf_wen}, 32'd0);
          end else begin
            e = wb_q.pop_front();
            check("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.rd});
            check("rf_wdata", rf_wdata, e.wdata);
            check("wb_cycle", cyc, e.cycle);
          end
        end
        if (misalign) begin
          if (mis_q.size() == 0) begin
            check("unexpected_misalign", {31'b0, misalign}, 32'd0);
          end else begin
            mc = mis_q.pop_front();
            check("misalign_cycle", cyc, mc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_rd     = 5'd3;
    in_addr   = 32'h0000_0010;
    in_funct3 = 3'd2;
    repeat (2) @(negedge clk);
    // Reset state, with a request held on the input that must not be taken.
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    check("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Directed loads.
    do_load(5'd5, 32'h8000_0004, 3'd2, 32'hDEAD_BEEF, 0);
    do_load(5'd7, 32'h1000_0003, 3'd0, 32'h8011_2233, 0);
    do_load(5'd8, 32'h1000_0003, 3'd4, 32'h8011_2233, 0);
    do_load(5'd9, 32'h1000_0002, 3'd1, 32'h8001_1234, 0);
    do_load(5'd10, 32'h1000_0002, 3'd5, 32'h8001_1234, 0);
    do_load(5'd11, 32'h2000_0008, 3'd2, 32'h1234_5678, 3);
    do_load(5'd12, 32'h2000_000C, 3'd2, 32'hCAFE_F00D, 0);
    do_load(5'd13, 32'h2000_0010, 3'd2, 32'h0BAD_CAFE, 0);
    do_load(5'd0, 32'h2000_0014, 3'd2, 32'hFFFF_FFFF, 0);
    do_load(5'd14, 32'h2000_0018, 3'd3, 32'h1111_2222, 0);
    do_load(5'd15, 32'h2000_001C, 3'd6, 32'h3333_4444, 1);
    do_load(5'd16, 32'h2000_0020, 3'd7, 32'h5555_6666, 0);
    do_load(5'd17, 32'h2000_0001, 3'd0, 32'h0000_7F00, 0);
    drain();

`ifdef LSU_MISALIGN_CHECK_EN
    do_load(5'd3, 32'h3000_0002, 3'd2, 32'h0, 0);
    do_load(5'd4, 32'h3000_0001, 3'd1, 32'h0, 0);
    drain();
`endif

    // Randomized traffic, including idle gaps and back-to-back requests.
    for (int i = 0; i < 200; i++) begin
      do_load(AW'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
              $urandom, $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset while in REQ, then a stray ack after release.
    hold_resp = 1'b1;
    mem_ack   = 1'b0;
    in_valid  = 1'b1;
    in_rd     = 5'd6;
    in_addr   = 32'h0000_0040;
    in_funct3 = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstreq_mem_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check("post_rst_rf_wen", {31'b0, rf_wen}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
    end
    hold_resp = 1'b0;

    drain();
    check("wb_queue_empty", wb_q.size(), 32'd0);
    check("mem_queue_empty", mem_q.size(), 32'd0);
    check("mis_queue_empty", mis_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
